// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad front end: key codes, FSM states
// and the row/column-to-code keymap.
package keypad_pkg;

  localparam logic [3:0] KEY_ADD   = 4'd10;
  localparam logic [3:0] KEY_EQUAL = 4'd11;
  localparam logic [3:0] KEY_CLEAR = 4'd12;

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } kp_state_t;

  function automatic logic [3:0] keymap(input logic [1:0] row_idx,
                                        input logic [1:0] col_idx);
    logic [3:0] code;
    code = 4'd0;
    case ({row_idx, col_idx})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = KEY_ADD;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = KEY_EQUAL;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = KEY_CLEAR;
      4'hC: code = 4'd13;
      4'hD: code = 4'd0;
      4'hE: code = 4'd14;
      4'hF: code = 4'd15;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/module_sincronizador.sv
// Two-flop synchroniser for the asynchronous keypad row pins; idles high
// to match the pull-ups.
module module_sincronizador #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      dout   <= '1;
    end else begin
      meta_q <= din;
      dout   <= meta_q;
    end
  end

endmodule

// File: rtl/module_teclado.sv
// 4x4 active-low keypad scanner with debounce; emits one key_code/key_pulse
// event per physical press.
module module_teclado
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 27000,
  parameter int unsigned DEBOUNCE_CYCLES = 540000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_code,
  output logic       key_pulse,
  output logic       key_held
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);

  logic [3:0]        row_s;
  kp_state_t         state_q, state_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [3:0]        col_q, col_d;
  logic [3:0]        row_lat_q, row_lat_d;
  logic [3:0]        code_q, code_d;
  logic              pulse_q, pulse_d;
  logic              held_q, held_d;
  logic [3:0]        col_next;

  module_sincronizador #(.WIDTH(4)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (row_i),
    .dout (row_s)
  );

  assign col_next = {col_q[2:0], col_q[3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SCAN;
      scan_q    <= '0;
      deb_q     <= '0;
      col_q     <= 4'b1110;
      row_lat_q <= '1;
      code_q    <= '0;
      pulse_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      scan_q    <= scan_d;
      deb_q     <= deb_d;
      col_q     <= col_d;
      row_lat_q <= row_lat_d;
      code_q    <= code_d;
      pulse_q   <= pulse_d;
      held_q    <= held_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    scan_d    = scan_q;
    deb_d     = deb_q;
    col_d     = col_q;
    row_lat_d = row_lat_q;
    code_d    = code_q;
    pulse_d   = 1'b0;
    held_d    = held_q;

    case (state_q)
      SCAN: begin
        if (scan_q == SCAN_LAST) begin
          scan_d = '0;
          if ($onehot(~row_s)) begin
            row_lat_d = row_s;
            deb_d     = '0;
            state_d   = DEB_PRESS;
          end else begin
            col_d = col_next;
          end
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
      DEB_PRESS: begin
        if (row_s != row_lat_q) begin
          deb_d   = '0;
          col_d   = col_next;
          state_d = SCAN;
        end else if (deb_q == DEB_LAST) begin
          code_d  = keymap(onehot_idx(~row_lat_q), onehot_idx(~col_q));
          pulse_d = 1'b1;
          held_d  = 1'b1;
          deb_d   = '0;
          state_d = PRESSED;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      PRESSED: begin
        // The cycle that first sees all rows high already counts as stable.
        if (&row_s) begin
          deb_d   = DEB_ONE;
          state_d = DEB_RELEASE;
        end
      end
      DEB_RELEASE: begin
        if (!(&row_s)) begin
          deb_d   = '0;
          state_d = PRESSED;
        end else if (deb_q == DEB_LAST) begin
          deb_d   = '0;
          held_d  = 1'b0;
          col_d   = col_next;
          state_d = SCAN;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  assign col_o     = col_q;
  assign key_code  = code_q;
  assign key_pulse = pulse_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_module_teclado.sv
// Directed bench for module_teclado with a keypad model and a scoreboard of
// expected key codes checked on every key_pulse.
module tb_module_teclado;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] key_code;
  logic       key_pulse;
  logic       key_held;

  logic [15:0] pressed = '0;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int pulse_cyc = 0;
  int exp_q[$];
  logic [3:0] prev_code  = '0;
  logic       prev_pulse = 1'b0;
  logic       prev_rst   = 1'b0;

  module_teclado #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_i    (row_i),
    .col_o    (col_o),
    .key_code (key_code),
    .key_pulse(key_pulse),
    .key_held (key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // A pressed key pulls its row low only while its column is driven.
  always_comb begin
    row_i = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (key_pulse === 1'b1) begin
      pulse_cnt++;
      pulse_cyc = cyc;
      check("pulse_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("key_code", key_code, exp_q.pop_front());
      check("held_with_pulse", key_held, 1);
      check("pulse_single_cycle", prev_pulse, 0);
    end
    if (rst_n && prev_rst && key_code !== prev_code)
      check("code_changes_on_pulse", key_pulse, 1);
    prev_pulse = key_pulse;
    prev_code  = key_code;
    prev_rst   = rst_n;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_col_idle(input int c);
    int k = 0;
    while (col_o[c] === 1'b0 && k < 20) begin
      step(1);
      k++;
    end
  endtask

  task automatic wait_row_low(input int r, output int t0);
    int k = 0;
    while (row_i[r] !== 1'b0 && k < 40) begin
      step(1);
      k++;
    end
    check("row_fall_timeout", row_i[r], 0);
    t0 = cyc;
  endtask

  task automatic wait_pulse(input int n0, input int lim);
    int k = 0;
    while (pulse_cnt == n0 && k < lim) begin
      step(1);
      k++;
    end
    check("pulse_timeout", pulse_cnt != n0, 1);
  endtask

  task automatic wait_held_low(input int lim, output int t);
    int k = 0;
    while (key_held !== 1'b0 && k < lim) begin
      step(1);
      k++;
    end
    check("held_fall_timeout", key_held, 0);
    t = cyc;
  endtask

  task automatic press_key(input int r, input int c, input int code, input int hold);
    int n0, t0, t_rel, t_fall;
    logic ok;
    wait_col_idle(c);
    n0 = pulse_cnt;
    pressed[r*4+c] = 1'b1;
    exp_q.push_back(code);
    wait_row_low(r, t0);
    wait_pulse(n0, 30);
    check("press_latency_le_15", (pulse_cyc - t0) <= 15, 1);
    ok = 1'b1;
    repeat (hold) begin
      step(1);
      if (key_held !== 1'b1) ok = 1'b0;
    end
    check("held_during_press", ok, 1);
    check("one_pulse_per_press", pulse_cnt, n0 + 1);
    pressed[r*4+c] = 1'b0;
    t_rel = cyc;
    wait_held_low(40, t_fall);
    check("release_to_held_fall", t_fall - t_rel, DEB + 2);
  endtask

  task automatic check_scan_restart();
    step(3);
    check("col0_after_reset", col_o, 4'b1110);
    step(1);
    check("col1_after_scan_div", col_o, 4'b1101);
  endtask

  initial begin
    int n0, t0, t;
    rst_n = 1'b0;
    step(3);
    check("reset_col_o", col_o, 4'b1110);
    check("reset_key_code", key_code, 0);
    check("reset_key_pulse", key_pulse, 0);
    check("reset_key_held", key_held, 0);
    rst_n = 1'b1;
    check_scan_restart();

    // Clean press of r1c1 held for about 100 cycles
    press_key(1, 1, 5, 88);

    // Bouncing r0c3, then stable
    wait_col_idle(3);
    n0 = pulse_cnt;
    pressed[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(3);
      pressed[3] = ~pressed[3];
    end
    check("bounce_no_pulse", pulse_cnt, n0);
    exp_q.push_back(10);
    wait_pulse(n0, 60);
    step(10);
    pressed[3] = 1'b0;
    wait_held_low(40, t);

    // Sequence 1, 2, ADD, CLEAR
    press_key(0, 0, 1, 20);
    press_key(0, 1, 2, 20);
    press_key(0, 3, 10, 20);
    press_key(2, 3, 12, 20);

    // Hold 7, add 9: only 7 is reported
    wait_col_idle(0);
    n0 = pulse_cnt;
    pressed[8] = 1'b1;
    exp_q.push_back(7);
    wait_row_low(2, t0);
    wait_pulse(n0, 30);
    pressed[10] = 1'b1;
    step(40);
    check("second_key_ignored", pulse_cnt, n0 + 1);
    pressed[8]  = 1'b0;
    pressed[10] = 1'b0;
    wait_held_low(40, t);
    step(30);
    check("no_pulse_after_two_keys", pulse_cnt, n0 + 1);
    press_key(2, 2, 9, 20);

    // Two rows low in the same column
    wait_col_idle(0);
    n0 = pulse_cnt;
    pressed[0] = 1'b1;
    pressed[8] = 1'b1;
    step(60);
    check("multi_row_no_pulse", pulse_cnt, n0);
    pressed = '0;
    step(10);

    // Reset during press debounce
    wait_col_idle(2);
    n0 = pulse_cnt;
    pressed[6] = 1'b1;
    wait_row_low(1, t0);
    step(6);
    rst_n = 1'b0;
    #1;
    check("midreset_col_o", col_o, 4'b1110);
    check("midreset_key_held", key_held, 0);
    check("midreset_key_pulse", key_pulse, 0);
    check("midreset_key_code", key_code, 0);
    pressed = '0;
    step(3);
    rst_n = 1'b1;
    check_scan_restart();
    step(40);
    check("no_pulse_after_reset", pulse_cnt, n0);
    press_key(1, 2, 6, 20);

    step(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, required finish before 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule
